// File: rtl/path_bank_if.sv
//------------------------------------------------------------------------------
// Module : path_bank_if
// Router-port bundle for path_bank: packet in/out with valid/ready handshake.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface path_bank_if #(
    parameter int NODE_W             = 10,
    parameter int MAX_EDGES_PER_LOAD = 4,
    parameter int COUNT_W            = 64
) ();
    // Packet = {addr.z, ctrl[1:0], data}; data is the widest of the three payloads.
    localparam int NE_W   = $clog2(MAX_EDGES_PER_LOAD + 1);
    localparam int PAR_W  = NE_W + MAX_EDGES_PER_LOAD * NODE_W;
    localparam int CFG_W  = NODE_W + 1;
    localparam int RES_W  = COUNT_W + 1;
    localparam int DATA_W = (RES_W > PAR_W) ? ((RES_W > CFG_W) ? RES_W : CFG_W)
                                            : ((PAR_W > CFG_W) ? PAR_W : CFG_W);
    localparam int PKT_W  = NODE_W + 2 + DATA_W;

    logic             router_valid_in;
    logic             router_ready_in;
    logic [PKT_W-1:0] router_in_pkt;
    logic             router_valid_out;
    logic             router_ready_out;
    logic [PKT_W-1:0] router_out_pkt;

    modport master (
        output router_valid_in, router_in_pkt, router_ready_out,
        input  router_ready_in, router_valid_out, router_out_pkt
    );

    modport slave (
        input  router_valid_in, router_in_pkt, router_ready_out,
        output router_ready_in, router_valid_out, router_out_pkt
    );
endinterface

`default_nettype wire

// File: rtl/path_bank.sv
//------------------------------------------------------------------------------
// Module : path_bank
// Single-bank DAG path counter: programmed by PARENTS/CONFIG, answers START.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module path_bank #(
    parameter int NODE_W             = 10,
    parameter int MAX_EDGES_PER_LOAD = 4,
    parameter int EDGE_DEPTH         = 4096,
    parameter int COUNT_W            = 64
) (
    input  wire logic clk,
    input  wire logic rst,
    path_bank_if.slave bus
);
    localparam int N_NODES = 1 << NODE_W;
    localparam int NE_W    = $clog2(MAX_EDGES_PER_LOAD + 1);
    localparam int EA_W    = $clog2(EDGE_DEPTH);
    localparam int EP_W    = EA_W + 1;
    localparam int PAR_W   = NE_W + MAX_EDGES_PER_LOAD * NODE_W;
    localparam int CFG_W   = NODE_W + 1;
    localparam int RES_W   = COUNT_W + 1;
    localparam int DATA_W  = (RES_W > PAR_W) ? ((RES_W > CFG_W) ? RES_W : CFG_W)
                                             : ((PAR_W > CFG_W) ? PAR_W : CFG_W);
    localparam int PKT_W   = NODE_W + 2 + DATA_W;

    localparam logic [1:0] c_CTRL_PARENTS = 2'd0;
    localparam logic [1:0] c_CTRL_CONFIG  = 2'd1;
    localparam logic [1:0] c_CTRL_START   = 2'd2;
    localparam logic [1:0] c_CTRL_RESULT  = 2'd3;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SCAN = 2'd1, S_EMIT = 2'd2} state_t;
    state_t r_state, w_state_nxt;

    logic [NODE_W-1:0]  r_edge_mem     [EDGE_DEPTH];
    logic [EA_W-1:0]    r_base         [N_NODES];
    logic [EP_W-1:0]    r_len          [N_NODES];
    logic [COUNT_W-1:0] r_cnt          [N_NODES];
    logic [NODE_W-1:0]  r_num_children [N_NODES];
    logic [N_NODES-1:0] r_has_list, r_is_you, r_cnt_vld;
    logic [EP_W-1:0]    r_edge_ptr, r_i;
    logic               r_overflow, r_changed;
    logic [NODE_W-1:0]  r_last_z, r_target, r_v;
    logic [NODE_W:0]    r_n_nodes;
    logic [COUNT_W-1:0] r_acc;

    logic [NODE_W-1:0]  w_in_z, w_par;
    logic [1:0]         w_in_ctrl;
    logic [DATA_W-1:0]  w_in_data;
    logic [NE_W-1:0]    w_num_edges, w_n_store;
    logic [NODE_W-1:0]  w_edge [MAX_EDGES_PER_LOAD];
    logic               w_ready, w_accept, w_parents_do, w_config_do, w_start_do;
    logic               w_new_list, w_drop, w_scan, w_in_list, w_node_end;
    logic               w_last_v, w_diff, w_done, w_valid;
    logic [NODE_W:0]    w_ref_max, w_z1;
    logic [EP_W-1:0]    w_len_old, w_cur_len;
    logic [COUNT_W-1:0] w_par_cnt, w_new, w_old, w_tgt_cnt;
    logic [PKT_W-1:0]   w_out_pkt;
    logic               w_unused;

    assign w_in_z      = bus.router_in_pkt[PKT_W-1 -: NODE_W];
    assign w_in_ctrl   = bus.router_in_pkt[DATA_W +: 2];
    assign w_in_data   = bus.router_in_pkt[DATA_W-1:0];
    assign w_num_edges = w_in_data[MAX_EDGES_PER_LOAD*NODE_W +: NE_W];

    genvar gi;
    generate
        for (gi = 0; gi < MAX_EDGES_PER_LOAD; gi++) begin : g_edge
            assign w_edge[gi] = w_in_data[gi*NODE_W +: NODE_W];
        end
    endgenerate

    assign w_ready      = (r_state == S_IDLE) && !rst;
    assign w_accept     = bus.router_valid_in && w_ready;
    assign w_parents_do = w_accept && (w_in_ctrl == c_CTRL_PARENTS) && (w_num_edges != '0);
    assign w_config_do  = w_accept && (w_in_ctrl == c_CTRL_CONFIG);
    assign w_start_do   = w_accept && (w_in_ctrl == c_CTRL_START);
    assign w_new_list   = !r_has_list[w_in_z] || (w_in_z != r_last_z);
    assign w_len_old    = w_new_list ? '0 : r_len[w_in_z];
    assign w_z1         = {1'b0, w_in_z} + (NODE_W+1)'(1);

    // Edges that fit form a prefix of the packet's slots; the rest are dropped.
    always_comb begin : p_load
        w_n_store = '0;
        w_drop    = 1'b0;
        w_ref_max = w_z1;
        for (int i = 0; i < MAX_EDGES_PER_LOAD; i++) begin
            if (NE_W'(i) < w_num_edges) begin
                if (({1'b0, r_edge_ptr} + (EP_W+1)'(i)) < (EP_W+1)'(EDGE_DEPTH)) begin
                    w_n_store = w_n_store + 1'b1;
                    if (({1'b0, w_edge[i]} + (NODE_W+1)'(1)) > w_ref_max)
                        w_ref_max = {1'b0, w_edge[i]} + (NODE_W+1)'(1);
                end else begin
                    w_drop = 1'b1;
                end
            end
        end
    end

    // Gauss-Seidel relaxation: parents are summed from the live count table.
    assign w_scan     = (r_state == S_SCAN);
    assign w_cur_len  = r_has_list[r_v] ? r_len[r_v] : '0;
    assign w_in_list  = r_i < w_cur_len;
    assign w_node_end = w_scan && !w_in_list;
    assign w_par      = r_edge_mem[EA_W'(r_base[r_v] + EA_W'(r_i))];
    assign w_par_cnt  = r_cnt_vld[w_par] ? r_cnt[w_par] : '0;
    assign w_new      = r_acc + COUNT_W'(r_is_you[r_v]);
    assign w_old      = r_cnt_vld[r_v] ? r_cnt[r_v] : '0;
    assign w_diff     = (w_new != w_old);
    assign w_last_v   = ({1'b0, r_v} + (NODE_W+1)'(1)) >= r_n_nodes;
    assign w_done     = w_node_end && w_last_v && !(r_changed || w_diff);
    assign w_tgt_cnt  = r_cnt_vld[r_target] ? r_cnt[r_target] : '0;

    always_ff @(posedge clk or posedge rst) begin : p_state
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin : p_fsm
        w_state_nxt = r_state;
        w_valid     = 1'b0;
        w_out_pkt   = '0;
        case (r_state)
            S_IDLE: if (w_start_do) w_state_nxt = S_SCAN;
            S_SCAN: if (w_done) w_state_nxt = S_EMIT;
            S_EMIT: begin
                w_valid   = 1'b1;
                w_out_pkt = {r_target, c_CTRL_RESULT, DATA_W'({w_tgt_cnt, r_overflow})};
                if (bus.router_ready_out) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin : p_ctrl
        if (rst) begin
            r_edge_ptr <= '0;
            r_overflow <= 1'b0;
            r_last_z   <= '0;
            r_n_nodes  <= '0;
            r_has_list <= '0;
            r_is_you   <= '0;
            r_cnt_vld  <= '0;
            r_target   <= '0;
            r_v        <= '0;
            r_i        <= '0;
            r_acc      <= '0;
            r_changed  <= 1'b0;
        end else begin
            if (w_parents_do) begin
                r_has_list[w_in_z] <= 1'b1;
                r_last_z           <= w_in_z;
                r_edge_ptr         <= r_edge_ptr + EP_W'(w_n_store);
                if (w_drop) r_overflow <= 1'b1;
                if (w_ref_max > r_n_nodes) r_n_nodes <= w_ref_max;
            end
            if (w_config_do) begin
                r_is_you[w_in_z] <= w_in_data[NODE_W];
                if (w_z1 > r_n_nodes) r_n_nodes <= w_z1;
            end
            if (w_start_do) begin
                r_cnt_vld <= '0;
                r_target  <= w_in_z;
                r_v       <= '0;
                r_i       <= '0;
                r_acc     <= '0;
                r_changed <= 1'b0;
            end
            if (w_scan) begin
                if (w_in_list) begin
                    r_acc <= r_acc + w_par_cnt;
                    r_i   <= r_i + EP_W'(1);
                end else begin
                    r_cnt_vld[r_v] <= 1'b1;
                    r_i            <= '0;
                    r_acc          <= '0;
                    if (w_last_v) begin
                        r_v       <= '0;
                        r_changed <= 1'b0;
                    end else begin
                        r_v       <= r_v + NODE_W'(1);
                        r_changed <= r_changed || w_diff;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin : p_mem
        if (w_parents_do) begin
            for (int i = 0; i < MAX_EDGES_PER_LOAD; i++)
                if (NE_W'(i) < w_n_store)
                    r_edge_mem[EA_W'(r_edge_ptr + EP_W'(i))] <= w_edge[i];
            if (w_new_list) r_base[w_in_z] <= EA_W'(r_edge_ptr);
            r_len[w_in_z] <= w_len_old + EP_W'(w_n_store);
        end
        if (w_config_do) r_num_children[w_in_z] <= w_in_data[NODE_W-1:0];
        if (w_node_end)  r_cnt[r_v] <= w_new;
    end

    assign bus.router_ready_in  = w_ready;
    assign bus.router_valid_out = w_valid;
    assign bus.router_out_pkt   = w_out_pkt;

    // num_children is kept for the host but never feeds the count.
    assign w_unused = &{1'b0, r_num_children[r_target], w_in_data, 1'b0};
endmodule

`default_nettype wire

// File: tb/tb_path_bank.sv
//------------------------------------------------------------------------------
// Module : tb_path_bank
// Randomised path-count bench for path_bank against a fixpoint reference model.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_path_bank;
    localparam int NODE_W = 10;
    localparam int MAXE   = 4;
    localparam int DEPTH  = 4096;
    localparam int CW     = 64;
    localparam int NE_W   = 3;
    localparam int DATA_W = CW + 1;
    localparam int PKT_W  = NODE_W + 2 + DATA_W;
    localparam int NN     = 1 << NODE_W;
    localparam int BUDGET = 30000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    path_bank_if #(.NODE_W(NODE_W), .MAX_EDGES_PER_LOAD(MAXE), .COUNT_W(CW)) bus ();
    path_bank #(.NODE_W(NODE_W), .MAX_EDGES_PER_LOAD(MAXE), .EDGE_DEPTH(DEPTH), .COUNT_W(CW))
        dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int n_checks = 0, n_fail = 0;
    int n_started = 0, n_results = 0, n_aborted = 0;
    logic [PKT_W-1:0] exp_pkt = '0;

    // Reference state: per-node parent queues, rebuilt from the programming rules.
    bit         m_you [NN];
    bit         m_has [NN];
    int         m_par [NN][$];
    int         m_ptr, m_last, m_n;
    bit         m_ovf;
    logic [CW-1:0] m_a [NN];
    logic [CW-1:0] m_b [NN];

    task automatic check(input bit ok, input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int v = 0; v < NN; v++) begin
            m_you[v] = 1'b0; m_has[v] = 1'b0; m_par[v].delete();
        end
        m_ptr = 0; m_last = 0; m_n = 0; m_ovf = 1'b0;
    endtask

    // Jacobi iteration to the unique fixpoint of paths(v) = you(v) + sum paths(parents).
    task automatic model_count(input int t, output logic [CW-1:0] r);
        bit ch;
        int it;
        logic [CW-1:0] s;
        for (int v = 0; v < m_n; v++) m_a[v] = '0;
        ch = 1'b1; it = 0;
        while (ch && it < m_n + 2) begin
            ch = 1'b0;
            for (int v = 0; v < m_n; v++) begin
                s = CW'(m_you[v]);
                for (int k = 0; k < m_par[v].size(); k++) s = s + m_a[m_par[v][k]];
                m_b[v] = s;
            end
            for (int v = 0; v < m_n; v++) begin
                if (m_b[v] != m_a[v]) ch = 1'b1;
                m_a[v] = m_b[v];
            end
            it++;
        end
        r = (t < m_n) ? m_a[t] : '0;
    endtask

    // Tasks enter and leave just after a rising edge.
    task automatic send(input logic [PKT_W-1:0] p);
        int g;
        bus.router_valid_in = 1'b1;
        bus.router_in_pkt   = p;
        g = 0;
        @(negedge clk);
        while (!bus.router_ready_in && g < BUDGET) begin @(negedge clk); g++; end
        if (g >= BUDGET) check(1'b0, "ready_in_timeout", 0, 1);
        @(posedge clk);
        #1 bus.router_valid_in = 1'b0;
    endtask

    task automatic send_parents(input int z, input int ne, input int e0, input int e1, input int e2, input int e3);
        logic [DATA_W-1:0] d;
        int ev[4];
        ev = '{e0, e1, e2, e3};
        d = '0;
        d[MAXE*NODE_W +: NE_W] = NE_W'(ne);
        for (int i = 0; i < MAXE; i++) d[i*NODE_W +: NODE_W] = NODE_W'(ev[i]);
        send({NODE_W'(z), 2'd0, d});
        if (ne > 0) begin
            if (!m_has[z] || m_last != z) begin m_par[z].delete(); m_has[z] = 1'b1; end
            m_last = z;
            if (z + 1 > m_n) m_n = z + 1;
            for (int i = 0; i < ne; i++) begin
                if (m_ptr < DEPTH) begin
                    m_par[z].push_back(ev[i]); m_ptr++;
                    if (ev[i] + 1 > m_n) m_n = ev[i] + 1;
                end else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic send_config(input int z, input bit you);
        logic [DATA_W-1:0] d;
        d = '0;
        d[NODE_W] = you;
        d[NODE_W-1:0] = NODE_W'($urandom_range(0, 7));
        send({NODE_W'(z), 2'd1, d});
        m_you[z] = you;
        if (z + 1 > m_n) m_n = z + 1;
    endtask

    task automatic arm_start(input int t, input bit use_lit, input logic [CW-1:0] lit, input bit lit_ovf);
        logic [CW-1:0] c;
        model_count(t, c);
        if (use_lit) check(c == lit && m_ovf == lit_ovf, "model_literal", {c, m_ovf}, {lit, lit_ovf});
        exp_pkt = {NODE_W'(t), 2'd3, DATA_W'({c, m_ovf})};
        n_started++;
        send({NODE_W'(t), 2'd2, DATA_W'(0)});
    endtask

    task automatic run_start(input int t, input int bp, input bit use_lit, input logic [CW-1:0] lit, input bit lit_ovf);
        int g;
        arm_start(t, use_lit, lit, lit_ovf);
        g = 0;
        do begin @(negedge clk); g++; end while (!bus.router_valid_out && g < BUDGET);
        if (!bus.router_valid_out) begin
            check(1'b0, "result_timeout", 0, 1);
            @(posedge clk); #1;
            return;
        end
        repeat (bp) @(negedge clk);
        @(posedge clk); #1 bus.router_ready_out = 1'b1;
        @(posedge clk); #1 bus.router_ready_out = 1'b0;
        @(negedge clk);
        check(bus.router_ready_in && !bus.router_valid_out, "idle_after_result",
              {bus.router_ready_in, bus.router_valid_out}, 2'b10);
        check(n_results == n_started - n_aborted, "result_count", n_results, n_started - n_aborted);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        n_aborted = n_started - n_results;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check(!bus.router_valid_out && !bus.router_ready_in && bus.router_out_pkt == '0,
                  "reset_outputs", {bus.router_valid_out, bus.router_ready_in, bus.router_out_pkt}, 0);
        end
        @(posedge clk); #1 rst = 1'b0;
        model_reset();
        @(negedge clk);
        check(bus.router_ready_in, "ready_after_reset", bus.router_ready_in, 1);
        @(posedge clk); #1;
    endtask

    // Every cycle a result is on the port it must match the model and be the only one due.
    always @(negedge clk) begin
        if (!rst && bus.router_valid_out) begin
            check((n_started - n_aborted) > n_results && bus.router_out_pkt == exp_pkt && !bus.router_ready_in,
                  "result_pkt", bus.router_out_pkt, exp_pkt);
            if (bus.router_ready_out) n_results++;
        end
    end

    task automatic random_dag();
        int ids[32];
        int k, np, c, tmp, j;
        int pl[$];
        for (int i = 0; i < 32; i++) ids[i] = i;
        for (int i = 31; i > 0; i--) begin
            j = $urandom_range(0, i); tmp = ids[i]; ids[i] = ids[j]; ids[j] = tmp;
        end
        k = $urandom_range(6, 14);
        for (int r = 0; r < k; r++) send_config(ids[r], (r == 0) || ($urandom_range(0, 4) == 0));
        for (int r = 1; r < k; r++) begin
            np = $urandom_range(0, (r < 6) ? r : 6);
            pl.delete();
            for (int i = 0; i < np; i++) pl.push_back(ids[$urandom_range(0, r - 1)]);
            for (int s = 0; s < np; s += 4) begin
                c = (np - s > 4) ? 4 : np - s;
                send_parents(ids[r], c, pl[s], (c > 1) ? pl[s+1] : 0, (c > 2) ? pl[s+2] : 0, (c > 3) ? pl[s+3] : 0);
            end
        end
        run_start(ids[$urandom_range(0, k - 1)], $urandom_range(0, 3), 1'b0, '0, 1'b0);
        run_start(ids[k - 1], $urandom_range(0, 3), 1'b0, '0, 1'b0);
    endtask

    initial begin
        bus.router_valid_in  = 1'b0;
        bus.router_in_pkt    = '0;
        bus.router_ready_out = 1'b0;
        model_reset();
        do_reset();

        // Diamond: 0 -> {1,2} -> 3
        send_config(0, 1'b1);
        send_parents(1, 1, 0, 0, 0, 0);
        send_parents(2, 1, 0, 0, 0, 0);
        send_parents(3, 2, 1, 2, 0, 0);
        send_parents(3, 0, 0, 0, 0, 0);
        run_start(3, 0, 1'b1, 64'd2, 1'b0);
        run_start(3, 10, 1'b1, 64'd2, 1'b0);

        // Six direct children of 0 feeding node 10 over two packets.
        for (int n = 11; n <= 16; n++) send_parents(n, 1, 0, 0, 0, 0);
        send_parents(10, 4, 11, 12, 13, 14);
        send_parents(10, 2, 15, 16, 0, 0);
        run_start(10, 1, 1'b1, 64'd6, 1'b0);

        send_config(20, 1'b0);
        run_start(20, 0, 1'b1, 64'd0, 1'b0);
        run_start(0, 2, 1'b1, 64'd1, 1'b0);

        for (int t = 0; t < 4; t++) begin
            do_reset();
            random_dag();
        end

        // Overflow: 4100 edges offered, 4096 fit.
        do_reset();
        send_config(1, 1'b1);
        for (int p = 0; p < 1025; p++) send_parents(5, 4, 1, 1, 1, 1);
        run_start(5, 0, 1'b1, 64'd4096, 1'b1);

        // Reset while scanning: no result, and programming is gone.
        arm_start(5, 1'b0, '0, 1'b0);
        repeat (50) @(posedge clk);
        #1;
        do_reset();
        repeat (5) @(negedge clk);
        check(n_results == n_started - n_aborted, "no_result_after_abort", n_results, n_started - n_aborted);
        @(posedge clk); #1;
        run_start(5, 0, 1'b1, 64'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule

`default_nettype wire
